// File: rtl/vi_timing_detect_pkg.sv
// Shared definitions for the vi_* video timing detector: FSM states and default field width.
package vi_timing_detect_pkg;

   localparam int VI_CW     = 12;
   localparam int VI_FIELDS = 8;   // h_total, h_sync, h_bporch, h_res, v_total, v_sync, v_bporch, v_res

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEASURE = 2'd1,
      ST_LOCKED  = 2'd2
   } vi_state_e;

endpackage

// File: rtl/vi_edge_det.sv
// One sync/enable input: polarity normalisation, single input register and rise/fall strobes.
module vi_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic sig,
   input  logic pol,
   output logic act,
   output logic rise,
   output logic fall
);

   logic sig_q;
   logic act_d;

   // NOTE: state is written with <= so every register samples pre-edge values, whatever the block order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sig_q <= ~pol;      // reset to the inactive level so no edge appears on release
         act_d <= 1'b0;
      end else begin
         sig_q <= sig;
         act_d <= act;
      end
   end

   assign act  = (sig_q == pol);
   assign rise = act & ~act_d;
   assign fall = ~act & act_d;

endmodule

// File: rtl/vi_timing_detect.sv
// Measures vs/hs/de stream timing, compares consecutive frames and publishes the set once stable.
module vi_timing_detect
   import vi_timing_detect_pkg::*;
#(
   parameter int CW          = VI_CW,
   parameter int LOCK_FRAMES = 2,
   parameter int TIMEOUT_CYC = 4000000
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          vi_vs,
   input  logic          vi_hs,
   input  logic          vi_de,
   input  logic          I_hs_pol,
   input  logic          I_vs_pol,
   output logic [CW-1:0] O_h_total,
   output logic [CW-1:0] O_h_sync,
   output logic [CW-1:0] O_h_bporch,
   output logic [CW-1:0] O_h_res,
   output logic [CW-1:0] O_v_total,
   output logic [CW-1:0] O_v_sync,
   output logic [CW-1:0] O_v_bporch,
   output logic [CW-1:0] O_v_res,
   output logic          O_locked,
   output logic          O_frame_done,
   output logic          O_err
);

   localparam int            SW         = VI_FIELDS * CW;
   localparam int            MW         = $clog2(LOCK_FRAMES + 1);
   localparam int            TW         = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] SAT        = '1;
   localparam logic [CW-1:0] ONE        = CW'(1);
   localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_FRAMES - 1);
   localparam logic [TW-1:0] TO_LIMIT   = TW'(TIMEOUT_CYC);

   logic hs_act, hs_rise, hs_fall;
   logic vs_act, vs_rise, vs_fall;
   logic de_act, de_rise, de_fall;

   vi_edge_det u_hs (.clk(clk), .rst_n(rst_n), .sig(vi_hs), .pol(I_hs_pol),
                     .act(hs_act), .rise(hs_rise), .fall(hs_fall));
   vi_edge_det u_vs (.clk(clk), .rst_n(rst_n), .sig(vi_vs), .pol(I_vs_pol),
                     .act(vs_act), .rise(vs_rise), .fall(vs_fall));
   vi_edge_det u_de (.clk(clk), .rst_n(rst_n), .sig(vi_de), .pol(1'b1),
                     .act(de_act), .rise(de_rise), .fall(de_fall));

   logic [CW-1:0] hcnt_q, vcnt_q, hpos, vpos;
   logic [CW-1:0] h_total_q, h_sync_q, h_bporch_q, h_res_q, de_start_q;
   logic [CW-1:0] v_sync_q, v_bporch_q, vres_q;
   logic [CW-1:0] h_total_nxt;
   logic          de_seen_q, sat_q, bad_q, cnt_sat;
   logic [SW-1:0] cap_set;
   logic          cap_valid;

   // hpos/vpos are this cycle's position in line/frame; the registers hold the previous one.
   always_comb begin
      hpos        = hs_rise ? '0 : ((hcnt_q == SAT) ? SAT : hcnt_q + ONE);
      vpos        = vs_rise ? '0 : ((hs_rise && vcnt_q != SAT) ? vcnt_q + ONE : vcnt_q);
      cnt_sat     = (hpos == SAT) || (vpos == SAT) || (vres_q == SAT);
      h_total_nxt = hs_rise ? hcnt_q + ONE : h_total_q;
      cap_set     = {h_total_nxt, h_sync_q, h_bporch_q, h_res_q,
                     vcnt_q + ONE, v_sync_q, v_bporch_q, vres_q};
      cap_valid   = de_seen_q & ~sat_q & ~bad_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hcnt_q     <= '0;
         vcnt_q     <= '0;
         h_total_q  <= '0;
         h_sync_q   <= '0;
         h_bporch_q <= '0;
         h_res_q    <= '0;
         de_start_q <= '0;
         v_sync_q   <= '0;
         v_bporch_q <= '0;
         vres_q     <= '0;
         de_seen_q  <= 1'b0;
         sat_q      <= 1'b0;
         bad_q      <= 1'b0;
      end else begin
         hcnt_q    <= hpos;
         vcnt_q    <= vpos;
         h_total_q <= h_total_nxt;
         if (hs_fall) h_sync_q <= hpos;
         if (de_rise) begin
            h_bporch_q <= hpos - h_sync_q;
            de_start_q <= hpos;
         end
         if (de_fall) h_res_q <= hpos - de_start_q;
         if (vs_fall) v_sync_q <= vpos;

         if (vs_rise) begin
            de_seen_q <= 1'b0;
            sat_q     <= 1'b0;
            bad_q     <= 1'b0;
            vres_q    <= '0;
         end else begin
            if (de_rise && !de_seen_q) v_bporch_q <= vpos - v_sync_q;
            if (de_rise) de_seen_q <= 1'b1;
            if (de_fall && vres_q != SAT) vres_q <= vres_q + ONE;
            if (cnt_sat) sat_q <= 1'b1;
            // de inside a sync pulse, across a line start, or ending before it began
            if ((de_rise && (hs_act || vs_act)) || (hs_rise && de_act) ||
                (de_fall && hpos < de_start_q))
               bad_q <= 1'b1;
         end
      end
   end

   vi_state_e     state_q, state_d;
   logic [MW-1:0] match_q, match_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic [SW-1:0] snap_q, snap_d, pub_q, pub_d;
   logic          snap_vld_q, snap_vld_d;
   logic          locked_q, locked_d, fd_q, fd_d, err_q, err_d;
   logic          timeout;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      match_d    = match_q;
      snap_d     = snap_q;
      snap_vld_d = snap_vld_q;
      pub_d      = pub_q;
      locked_d   = locked_q;
      fd_d       = 1'b0;
      err_d      = 1'b0;
      timeout    = (to_cnt_q == TO_LIMIT);
      to_cnt_d   = (state_q == ST_IDLE || vs_rise) ? '0 :
                   (timeout ? to_cnt_q : to_cnt_q + TW'(1));

      unique case (state_q)
         ST_IDLE: begin
            if (vs_rise) begin
               state_d    = ST_MEASURE;
               match_d    = '0;
               snap_vld_d = 1'b0;   // the frame before the first vs rise is partial
            end
         end
         ST_MEASURE: begin
            if (vs_rise) begin
               fd_d       = 1'b1;
               snap_d     = cap_set;
               snap_vld_d = cap_valid;
               if (cap_valid && snap_vld_q && cap_set == snap_q) begin
                  match_d = match_q + MW'(1);
                  if (match_q == MATCH_LAST) begin
                     state_d  = ST_LOCKED;
                     pub_d    = cap_set;
                     locked_d = 1'b1;
                  end
               end else begin
                  match_d = '0;
               end
            end else if (timeout) begin
               state_d = ST_IDLE;
            end
         end
         ST_LOCKED: begin
            // the snapshot stays at the locked set so a single bad frame costs only one compare
            if (vs_rise) begin
               fd_d = 1'b1;
               if (!(cap_valid && cap_set == snap_q)) begin
                  state_d  = ST_MEASURE;
                  match_d  = '0;
                  locked_d = 1'b0;
                  err_d    = 1'b1;
               end
            end else if (timeout) begin
               state_d  = ST_IDLE;
               locked_d = 1'b0;
               err_d    = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: snapshot and published sets are plain registers, cleared so outputs read 0 after reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         match_q    <= '0;
         to_cnt_q   <= '0;
         snap_q     <= '0;
         snap_vld_q <= 1'b0;
         pub_q      <= '0;
         locked_q   <= 1'b0;
         fd_q       <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         match_q    <= match_d;
         to_cnt_q   <= to_cnt_d;
         snap_q     <= snap_d;
         snap_vld_q <= snap_vld_d;
         pub_q      <= pub_d;
         locked_q   <= locked_d;
         fd_q       <= fd_d;
         err_q      <= err_d;
      end
   end

   assign {O_h_total, O_h_sync, O_h_bporch, O_h_res,
           O_v_total, O_v_sync, O_v_bporch, O_v_res} = pub_q;
   assign O_locked     = locked_q;
   assign O_frame_done = fd_q;
   assign O_err        = err_q;

endmodule

// File: tb/tb_vi_timing_detect.sv
// Directed bench for vi_timing_detect using a scaled-down TPG raster (40x20 clk/lines).
module tb_vi_timing_detect;

   localparam int CW          = 12;
   localparam int LOCK_FRAMES = 2;
   localparam int TIMEOUT_CYC = 2000;
   localparam int CLK_P       = 10;
   localparam int H = 40, HS = 4, HBP = 6, HRES = 24;
   localparam int V = 20, VS = 2, VBP = 3, VRES = 12;
   localparam logic [8*CW-1:0] EXP = {12'd40, 12'd4, 12'd6, 12'd24, 12'd20, 12'd2, 12'd3, 12'd12};
   localparam time LOCK_LAT = 2 * CLK_P + CLK_P / 2 - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          vi_vs, vi_hs, vi_de;
   logic          I_hs_pol = 1'b1, I_vs_pol = 1'b1;
   logic [CW-1:0] O_h_total, O_h_sync, O_h_bporch, O_h_res;
   logic [CW-1:0] O_v_total, O_v_sync, O_v_bporch, O_v_res;
   logic          O_locked, O_frame_done, O_err;
   logic [8*CW-1:0] meas;

   int  errors = 0, checks = 0;
   int  fd_cnt = 0, err_cnt = 0, lock_rises = 0;
   logic locked_d = 1'b0;
   time lock_t = 0, vs_t = 0;

   vi_timing_detect #(.CW(CW), .LOCK_FRAMES(LOCK_FRAMES), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .clk(clk), .rst_n(rst_n), .vi_vs(vi_vs), .vi_hs(vi_hs), .vi_de(vi_de),
      .I_hs_pol(I_hs_pol), .I_vs_pol(I_vs_pol),
      .O_h_total(O_h_total), .O_h_sync(O_h_sync), .O_h_bporch(O_h_bporch), .O_h_res(O_h_res),
      .O_v_total(O_v_total), .O_v_sync(O_v_sync), .O_v_bporch(O_v_bporch), .O_v_res(O_v_res),
      .O_locked(O_locked), .O_frame_done(O_frame_done), .O_err(O_err)
   );

   assign meas = {O_h_total, O_h_sync, O_h_bporch, O_h_res, O_v_total, O_v_sync, O_v_bporch, O_v_res};

   always #(CLK_P / 2) clk = ~clk;

   always @(negedge clk) begin
      if (O_frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
      if (O_err === 1'b1) err_cnt <= err_cnt + 1;
      if (O_locked === 1'b1 && locked_d !== 1'b1) begin
         lock_t     <= $time;
         lock_rises <= lock_rises + 1;
      end
      locked_d <= O_locked;
   end

   task automatic drive_idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         vi_vs = ~I_vs_pol;
         vi_hs = ~I_hs_pol;
         vi_de = 1'b0;
      end
   endtask

   task automatic run_frame(input int res_adj, input bit de_en, input int l0, input int l1);
      bit hs, vs, de;
      for (int ln = l0; ln <= l1; ln++) begin
         for (int px = 0; px < H; px++) begin
            @(posedge clk); #1;
            hs = (px < HS);
            vs = (ln < VS);
            de = de_en && ln >= VS + VBP && ln < VS + VBP + VRES &&
                 px >= HS + HBP && px < HS + HBP + HRES + res_adj;
            vi_hs = (hs == I_hs_pol);
            vi_vs = (vs == I_vs_pol);
            vi_de = de;
            if (ln == 0 && px == 0) vs_t = $time;
         end
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      vi_vs = ~I_vs_pol;
      vi_hs = ~I_hs_pol;
      vi_de = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      I_hs_pol = 1'b1;
      I_vs_pol = 1'b1;
      do_reset();
      checks++;
      if (meas !== '0) begin
         errors++; $display("FAIL reset_fields: got %h expected 0", meas);
      end
      checks++;
      if ({O_locked, O_frame_done, O_err} !== 3'b000) begin
         errors++; $display("FAIL reset_flags: got %b expected 000", {O_locked, O_frame_done, O_err});
      end
   endtask

   task automatic test_tpg_lock(input string tag);
      int f0, e0;
      f0 = fd_cnt; e0 = err_cnt;
      repeat (3) run_frame(0, 1'b1, 0, V - 1);
      checks++;
      if (O_locked !== 1'b0) begin
         errors++; $display("FAIL %s_early_lock: got %b expected 0", tag, O_locked);
      end
      run_frame(0, 1'b1, 0, V - 1);
      checks++;
      if (O_locked !== 1'b1) begin
         errors++; $display("FAIL %s_locked: got %b expected 1", tag, O_locked);
      end
      checks++;
      if (lock_t !== vs_t + LOCK_LAT) begin
         errors++; $display("FAIL %s_lock_time: got %0t expected %0t", tag, lock_t, vs_t + LOCK_LAT);
      end
      checks++;
      if (meas !== EXP) begin
         errors++; $display("FAIL %s_fields: got %h expected %h", tag, meas, EXP);
      end
      checks++;
      if (fd_cnt - f0 !== 3) begin
         errors++; $display("FAIL %s_frame_done: got %0d expected 3", tag, fd_cnt - f0);
      end
      checks++;
      if (err_cnt - e0 !== 0) begin
         errors++; $display("FAIL %s_err: got %0d expected 0", tag, err_cnt - e0);
      end
   endtask

   task automatic test_bad_frame();
      int e0;
      e0 = err_cnt;
      run_frame(-1, 1'b1, 0, V - 1);
      run_frame(0, 1'b1, 0, V - 1);
      checks++;
      if (err_cnt - e0 !== 1) begin
         errors++; $display("FAIL bad_err_pulses: got %0d expected 1", err_cnt - e0);
      end
      checks++;
      if (O_locked !== 1'b0) begin
         errors++; $display("FAIL bad_unlock: got %b expected 0", O_locked);
      end
      checks++;
      if (O_h_res !== 12'd24) begin
         errors++; $display("FAIL bad_hold_h_res: got %0d expected 24", O_h_res);
      end
      run_frame(0, 1'b1, 0, V - 1);
      checks++;
      if (O_locked !== 1'b0) begin
         errors++; $display("FAIL bad_relock_early: got %b expected 0", O_locked);
      end
      run_frame(0, 1'b1, 0, V - 1);
      checks++;
      if (O_locked !== 1'b1) begin
         errors++; $display("FAIL bad_relock: got %b expected 1", O_locked);
      end
      checks++;
      if (meas !== EXP) begin
         errors++; $display("FAIL bad_relock_fields: got %h expected %h", meas, EXP);
      end
   endtask

   task automatic test_timeout();
      int e0, f0;
      e0 = err_cnt; f0 = fd_cnt;
      drive_idle(TIMEOUT_CYC + 100);
      checks++;
      if (err_cnt - e0 !== 1) begin
         errors++; $display("FAIL timeout_err_pulses: got %0d expected 1", err_cnt - e0);
      end
      checks++;
      if (O_locked !== 1'b0) begin
         errors++; $display("FAIL timeout_unlock: got %b expected 0", O_locked);
      end
      checks++;
      if (fd_cnt - f0 !== 0) begin
         errors++; $display("FAIL timeout_frame_done: got %0d expected 0", fd_cnt - f0);
      end
      test_tpg_lock("timeout_restart");
   endtask

   task automatic test_reset_mid_frame();
      run_frame(0, 1'b1, 0, 9);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      checks++;
      if (meas !== '0) begin
         errors++; $display("FAIL midrst_fields: got %h expected 0", meas);
      end
      checks++;
      if ({O_locked, O_frame_done, O_err} !== 3'b000) begin
         errors++; $display("FAIL midrst_flags: got %b expected 000", {O_locked, O_frame_done, O_err});
      end
      run_frame(0, 1'b1, 10, V - 1);
      test_tpg_lock("midrst_relock");
   endtask

   task automatic test_polarity();
      I_hs_pol = 1'b0;
      I_vs_pol = 1'b0;
      do_reset();
      test_tpg_lock("neg_pol");
   endtask

   task automatic test_no_de();
      int f0, r0, e0;
      I_hs_pol = 1'b1;
      I_vs_pol = 1'b1;
      do_reset();
      f0 = fd_cnt; r0 = lock_rises; e0 = err_cnt;
      repeat (5) run_frame(0, 1'b0, 0, V - 1);
      checks++;
      if (fd_cnt - f0 !== 4) begin
         errors++; $display("FAIL no_de_frame_done: got %0d expected 4", fd_cnt - f0);
      end
      checks++;
      if (lock_rises - r0 !== 0 || O_locked !== 1'b0) begin
         errors++; $display("FAIL no_de_lock: got rises=%0d locked=%b expected 0/0", lock_rises - r0, O_locked);
      end
      checks++;
      if (err_cnt - e0 !== 0) begin
         errors++; $display("FAIL no_de_err: got %0d expected 0", err_cnt - e0);
      end
   endtask

   initial begin
      vi_vs = 1'b0;
      vi_hs = 1'b0;
      vi_de = 1'b0;
      test_reset();
      test_tpg_lock("tpg");
      test_bad_frame();
      test_timeout();
      test_reset_mid_frame();
      test_polarity();
      test_no_de();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
